// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hold/flush sequencer:
// controller states, pipeline-register indices and per-action hold/bubble masks.
package pipe_ctrl_pkg;

  localparam int STG_CNT    = 4;
  localparam int STG_IF_ID  = 0;
  localparam int STG_ID_EX  = 1;
  localparam int STG_EX_MEM = 2;
  localparam int STG_MEM_WB = 3;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MC_WAIT  = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  typedef logic [STG_CNT-1:0] stg_mask_t;

  // hold selects which registers stop loading; bubble picks NOP over keep for those.
  typedef struct packed {
    stg_mask_t hold;
    stg_mask_t bubble;
  } stg_act_t;

  localparam stg_mask_t BIT_IF_ID  = stg_mask_t'(1 << STG_IF_ID);
  localparam stg_mask_t BIT_ID_EX  = stg_mask_t'(1 << STG_ID_EX);
  localparam stg_mask_t BIT_EX_MEM = stg_mask_t'(1 << STG_EX_MEM);
  localparam stg_mask_t BIT_MEM_WB = stg_mask_t'(1 << STG_MEM_WB);
  localparam stg_mask_t MASK_ALL   = BIT_IF_ID | BIT_ID_EX | BIT_EX_MEM | BIT_MEM_WB;

  localparam stg_act_t ACT_NONE      = '{hold: '0, bubble: '0};
  localparam stg_act_t ACT_FLUSH     = '{hold: MASK_ALL, bubble: MASK_ALL};
  localparam stg_act_t ACT_MEM_STALL = '{hold: MASK_ALL, bubble: BIT_MEM_WB};
  localparam stg_act_t ACT_JUMP      = '{hold: BIT_IF_ID | BIT_ID_EX, bubble: BIT_IF_ID | BIT_ID_EX};
  localparam stg_act_t ACT_MC        = '{hold: BIT_IF_ID | BIT_ID_EX | BIT_EX_MEM, bubble: BIT_EX_MEM};
  localparam stg_act_t ACT_LOAD_USE  = '{hold: BIT_IF_ID | BIT_ID_EX, bubble: BIT_ID_EX};

endpackage

// File: rtl/pipe_mem_wdog.sv
// Data-bus wait watchdog: clearable, enabled up-counter flagging the last
// permitted wait cycle (count == LIMIT-1).
module pipe_mem_wdog #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] r_count;

  // NOTE: reset is synchronous here, so rstn sits inside the clocked branch and not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rstn || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expire = (r_count == CW'(LIMIT - 1));

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Stall/flush sequencer for the 5-stage core's pipeline registers, PC hold and redirect.
// Optional interrupt redirect is enabled by defining PIPE_CTRL_IRQ_EN.
module pipe_hold_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int N_STG       = STG_CNT,
  parameter int AW          = 32,
  parameter int MEM_TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_use_i,
  input  logic             jump_req_i,
  input  logic [AW-1:0]    jump_addr_i,
  input  logic             mc_start_i,
  input  logic             mc_done_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  input  logic             irq_i,
  input  logic [AW-1:0]    irq_vec_i,
  output logic [N_STG-1:0] stg_hold_o,
  output logic [N_STG-1:0] stg_bubble_o,
  output logic             pc_hold_o,
  output logic             jump_en_o,
  output logic [AW-1:0]    jump_addr_o,
  output logic             bus_err_o,
  output logic             irq_ack_o
);

  state_e   r_state;
  state_e   w_next_state;
  stg_act_t w_act;
  logic     w_mem_stall;
  logic     w_wdog_en;
  logic     w_wdog_clr;
  logic     w_wdog_expire;
  logic     w_irq;
  logic [AW-1:0] w_irq_vec;

`ifdef PIPE_CTRL_IRQ_EN
  assign w_irq     = irq_i;
  assign w_irq_vec = irq_vec_i;
`else
  logic w_unused_irq;
  assign w_irq        = 1'b0;
  assign w_irq_vec    = '0;
  assign w_unused_irq = irq_i ^ (^irq_vec_i);
`endif

  assign w_mem_stall = mem_req_i & ~mem_ready_i;

  pipe_mem_wdog #(
    .LIMIT (MEM_TIMEOUT)
  ) u_wdog (
    .clk      (clk),
    .rstn     (rstn),
    .i_clr    (w_wdog_clr),
    .i_en     (w_wdog_en),
    .o_expire (w_wdog_expire)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    w_next_state = r_state;
    w_act        = ACT_NONE;
    pc_hold_o    = 1'b0;
    jump_en_o    = 1'b0;
    jump_addr_o  = '0;
    bus_err_o    = 1'b0;
    irq_ack_o    = 1'b0;
    w_wdog_en    = 1'b0;
    w_wdog_clr   = 1'b0;

    case (r_state)
      ST_RUN: begin
        // The entry cycle counts toward the timeout, so the stall spans MEM_TIMEOUT cycles.
        if (w_mem_stall) begin
          w_act        = ACT_MEM_STALL;
          pc_hold_o    = 1'b1;
          w_wdog_en    = 1'b1;
          w_next_state = ST_MEM_WAIT;
        end else if (jump_req_i) begin
          w_act       = ACT_JUMP;
          jump_en_o   = 1'b1;
          jump_addr_o = jump_addr_i;
        end else if (w_irq) begin
          w_act       = ACT_JUMP;
          jump_en_o   = 1'b1;
          jump_addr_o = w_irq_vec;
          irq_ack_o   = 1'b1;
        end else if (mc_start_i) begin
          w_act        = ACT_MC;
          pc_hold_o    = 1'b1;
          w_next_state = ST_MC_WAIT;
        end else if (load_use_i) begin
          w_act     = ACT_LOAD_USE;
          pc_hold_o = 1'b1;
        end
      end

      ST_MC_WAIT: begin
        if (mc_done_i) begin
          w_next_state = ST_RUN;
        end else begin
          w_act     = ACT_MC;
          pc_hold_o = 1'b1;
          if (w_mem_stall) begin
            w_act.hold[STG_MEM_WB]   = 1'b1;
            w_act.bubble[STG_MEM_WB] = 1'b1;
          end
        end
      end

      ST_MEM_WAIT: begin
        if (mem_ready_i) begin
          w_wdog_clr   = 1'b1;
          w_next_state = ST_RUN;
        end else if (w_wdog_expire) begin
          bus_err_o    = 1'b1;
          w_wdog_clr   = 1'b1;
          w_next_state = ST_RUN;
        end else begin
          w_act     = ACT_MEM_STALL;
          pc_hold_o = 1'b1;
          w_wdog_en = 1'b1;
        end
      end

      default: w_next_state = ST_RUN;
    endcase

    // Reset overrides everything in the same cycle: whole pipe flushed, no redirect.
    if (!rstn) begin
      w_act       = ACT_FLUSH;
      pc_hold_o   = 1'b0;
      jump_en_o   = 1'b0;
      jump_addr_o = '0;
      bus_err_o   = 1'b0;
      irq_ack_o   = 1'b0;
      w_wdog_en   = 1'b0;
    end
  end

  assign stg_hold_o   = N_STG'(w_act.hold);
  assign stg_bubble_o = N_STG'(w_act.bubble);

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed self-checking bench for pipe_hold_ctrl (MEM_TIMEOUT=8, AW=32);
// covers the interrupt path when PIPE_CTRL_IRQ_EN is defined.
module tb_pipe_hold_ctrl;

  localparam int N_STG = 4;
  localparam int AW    = 32;
  localparam int TMO   = 8;

  logic             clk = 1'b0;
  logic             rstn;
  logic             load_use_i, jump_req_i, mc_start_i, mc_done_i;
  logic             mem_req_i, mem_ready_i, irq_i;
  logic [AW-1:0]    jump_addr_i, irq_vec_i;
  logic [N_STG-1:0] stg_hold_o, stg_bubble_o;
  logic             pc_hold_o, jump_en_o, bus_err_o, irq_ack_o;
  logic [AW-1:0]    jump_addr_o;

  int n_vec = 0;
  int n_err = 0;

  pipe_hold_ctrl #(.N_STG(N_STG), .AW(AW), .MEM_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .load_use_i   (load_use_i),
    .jump_req_i   (jump_req_i),
    .jump_addr_i  (jump_addr_i),
    .mc_start_i   (mc_start_i),
    .mc_done_i    (mc_done_i),
    .mem_req_i    (mem_req_i),
    .mem_ready_i  (mem_ready_i),
    .irq_i        (irq_i),
    .irq_vec_i    (irq_vec_i),
    .stg_hold_o   (stg_hold_o),
    .stg_bubble_o (stg_bubble_o),
    .pc_hold_o    (pc_hold_o),
    .jump_en_o    (jump_en_o),
    .jump_addr_o  (jump_addr_o),
    .bus_err_o    (bus_err_o),
    .irq_ack_o    (irq_ack_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the hand-computed expectation for this cycle.
  task automatic expect_out(input string tag, input logic [3:0] hold, input logic [3:0] bub,
                            input logic pc, input logic je, input logic [31:0] ja,
                            input logic be, input logic ack);
    chk({tag, ".hold"},   32'(stg_hold_o),   32'(hold));
    chk({tag, ".bubble"}, 32'(stg_bubble_o), 32'(bub));
    chk({tag, ".pc_hold"}, 32'(pc_hold_o),   32'(pc));
    chk({tag, ".jump_en"}, 32'(jump_en_o),   32'(je));
    chk({tag, ".jump_addr"}, jump_addr_o,    ja);
    chk({tag, ".bus_err"}, 32'(bus_err_o),   32'(be));
    chk({tag, ".irq_ack"}, 32'(irq_ack_o),   32'(ack));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    load_use_i = 0; jump_req_i = 0; mc_start_i = 0; mc_done_i = 0;
    mem_req_i = 0; mem_ready_i = 0; irq_i = 0;
    jump_addr_i = '0; irq_vec_i = '0;
  endtask

  initial begin
    clear_inputs();
    rstn = 1'b0;
    jump_req_i = 1'b1; jump_addr_i = 32'h44;
    #1;
    expect_out("reset", 4'hF, 4'hF, 0, 0, 0, 0, 0);
    next_cycle();
    next_cycle();
    rstn = 1'b1;
    clear_inputs();
    #1;
    expect_out("idle0", 4'h0, 4'h0, 0, 0, 0, 0, 0);

    // Load-use: single-cycle bubble into ID/EX.
    next_cycle();
    load_use_i = 1; #1;
    expect_out("load_use", 4'h3, 4'h2, 1, 0, 0, 0, 0);
    next_cycle();
    clear_inputs(); #1;
    expect_out("load_use_after", 4'h0, 4'h0, 0, 0, 0, 0, 0);

    // Jump outranks load-use.
    next_cycle();
    jump_req_i = 1; load_use_i = 1; jump_addr_i = 32'h80; #1;
    expect_out("jump_lu", 4'h3, 4'h3, 0, 1, 32'h80, 0, 0);
    next_cycle();
    clear_inputs(); #1;
    expect_out("jump_after", 4'h0, 4'h0, 0, 0, 0, 0, 0);

    // Multi-cycle op: 34 held cycles, release on done.
    next_cycle();
    mc_start_i = 1; #1;
    expect_out("mc_start", 4'h7, 4'h4, 1, 0, 0, 0, 0);
    for (int i = 1; i < 34; i++) begin
      next_cycle();
      clear_inputs();
      if (i == 10) begin jump_req_i = 1; load_use_i = 1; jump_addr_i = 32'h200; end
      if (i == 20) begin mem_req_i = 1; end
      #1;
      if (i == 20) expect_out("mc_wait_mem", 4'hF, 4'hC, 1, 0, 0, 0, 0);
      else         expect_out("mc_wait", 4'h7, 4'h4, 1, 0, 0, 0, 0);
    end
    next_cycle();
    clear_inputs(); mc_done_i = 1; #1;
    expect_out("mc_done", 4'h0, 4'h0, 0, 0, 0, 0, 0);
    next_cycle();
    clear_inputs(); #1;
    expect_out("mc_after", 4'h0, 4'h0, 0, 0, 0, 0, 0);

    // mc_start outranks load-use.
    next_cycle();
    mc_start_i = 1; load_use_i = 1; #1;
    expect_out("mc_lu", 4'h7, 4'h4, 1, 0, 0, 0, 0);
    next_cycle();
    clear_inputs(); mc_done_i = 1; #1;
    expect_out("mc_lu_done", 4'h0, 4'h0, 0, 0, 0, 0, 0);

    // Memory stall outranks jump; ready releases next cycle.
    next_cycle();
    clear_inputs(); mem_req_i = 1; jump_req_i = 1; jump_addr_i = 32'h300; #1;
    expect_out("mem_jump", 4'hF, 4'h8, 1, 0, 0, 0, 0);
    next_cycle();
    clear_inputs(); mem_req_i = 1; mem_ready_i = 1; #1;
    expect_out("mem_ready1", 4'h0, 4'h0, 0, 0, 0, 0, 0);

    // Timeout: 7 stalled cycles, bus error and release in the 8th.
    for (int i = 0; i < TMO; i++) begin
      next_cycle();
      clear_inputs(); mem_req_i = 1; #1;
      if (i == TMO - 1) expect_out("tmo_err", 4'h0, 4'h0, 0, 0, 0, 1, 0);
      else              expect_out("tmo_wait", 4'hF, 4'h8, 1, 0, 0, 0, 0);
    end
    next_cycle();
    clear_inputs(); #1;
    expect_out("tmo_after", 4'h0, 4'h0, 0, 0, 0, 0, 0);

    // Ready in the timeout cycle wins: no bus error.
    for (int i = 0; i < TMO; i++) begin
      next_cycle();
      clear_inputs(); mem_req_i = 1;
      if (i == TMO - 1) mem_ready_i = 1;
      #1;
      if (i == TMO - 1) expect_out("rdy_last", 4'h0, 4'h0, 0, 0, 0, 0, 0);
      else              expect_out("rdy_wait", 4'hF, 4'h8, 1, 0, 0, 0, 0);
    end
    next_cycle();
    clear_inputs(); #1;
    expect_out("rdy_after", 4'h0, 4'h0, 0, 0, 0, 0, 0);

    // Reset in the 3rd stall cycle, then a fresh full-length timeout.
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      clear_inputs(); mem_req_i = 1;
      if (i == 2) rstn = 1'b0;
      #1;
      if (i == 2) expect_out("rst_mid", 4'hF, 4'hF, 0, 0, 0, 0, 0);
      else        expect_out("rst_wait", 4'hF, 4'h8, 1, 0, 0, 0, 0);
    end
    next_cycle();
    rstn = 1'b1; clear_inputs(); #1;
    expect_out("rst_release", 4'h0, 4'h0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TMO; i++) begin
      next_cycle();
      clear_inputs(); mem_req_i = 1; #1;
      if (i == TMO - 1) expect_out("rst_tmo_err", 4'h0, 4'h0, 0, 0, 0, 1, 0);
      else              expect_out("rst_tmo_wait", 4'hF, 4'h8, 1, 0, 0, 0, 0);
    end
    next_cycle();
    clear_inputs(); #1;
    expect_out("rst_tmo_after", 4'h0, 4'h0, 0, 0, 0, 0, 0);

`ifdef PIPE_CTRL_IRQ_EN
    // Jump beats interrupt; interrupt taken the following cycle.
    next_cycle();
    irq_i = 1; irq_vec_i = 32'h100; jump_req_i = 1; jump_addr_i = 32'h80; #1;
    expect_out("irq_jump", 4'h3, 4'h3, 0, 1, 32'h80, 0, 0);
    next_cycle();
    clear_inputs(); irq_i = 1; irq_vec_i = 32'h100; mc_start_i = 1; #1;
    expect_out("irq_take", 4'h3, 4'h3, 0, 1, 32'h100, 0, 1);
    next_cycle();
    clear_inputs(); #1;
    expect_out("irq_after", 4'h0, 4'h0, 0, 0, 0, 0, 0);
`else
    // Interrupt inputs have no effect in the default build.
    next_cycle();
    irq_i = 1; irq_vec_i = 32'h100; #1;
    expect_out("irq_off", 4'h0, 4'h0, 0, 0, 0, 0, 0);
    next_cycle();
    clear_inputs(); #1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
